// File: rtl/data_memory_busywait.sv
// Multi-cycle RV32 data memory in the MEM stage; holds busywait for LATENCY+1
// cycles per access, does LB/LH/LW/LBU/LHU/SB/SH/SW and flags bad accesses.
// Ports: clk, reset (async, active-low), mem_read, mem_write, funct3, address,
// writedata in; readdata (registered), busywait (comb), misaligned (registered) out.
module data_memory_busywait #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic        misaligned
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int AW = ADDR_BITS + 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;

  logic [31:0]          mem_array [0:(1<<ADDR_BITS)-1];
  logic [ADDR_BITS-1:0] idx;
  logic [1:0]           lane;
  logic [4:0]           shamt;
  logic [31:0]          rd_word;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          ld_val;
  logic [31:0]          wr_word;
  logic                 err;
  logic                 mem_we;
  logic                 req;

  // Upper address bits alias onto the array.
  logic unused_addr;
  assign unused_addr = ^address[31:AW];

  assign req     = mem_read | mem_write;
  assign idx     = addr_q[AW-1:2];
  assign lane    = addr_q[1:0];
  assign shamt   = {lane, 3'b000};
  assign rd_word = mem_array[idx];
  assign ld_byte = rd_word[shamt +: 8];
  assign ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    err     = 1'b0;
    ld_val  = '0;
    wr_word = rd_word;
    if (we_q) begin
      unique case (f3_q)
        3'b000: wr_word[shamt +: 8] = wdata_q[7:0];
        3'b001: begin
          err = lane[0];
          if (lane[1]) wr_word[31:16] = wdata_q[15:0];
          else         wr_word[15:0]  = wdata_q[15:0];
        end
        3'b010: begin
          err     = |lane;
          wr_word = wdata_q;
        end
        default: err = 1'b1;
      endcase
    end else begin
      unique case (f3_q)
        3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
        3'b001: begin
          err    = lane[0];
          ld_val = {{16{ld_half[15]}}, ld_half};
        end
        3'b010: begin
          err    = |lane;
          ld_val = rd_word;
        end
        3'b100: ld_val = {24'b0, ld_byte};
        3'b101: begin
          err    = lane[0];
          ld_val = {16'b0, ld_half};
        end
        default: err = 1'b1;
      endcase
    end
  end

  assign mem_we = (state_q == S_ACCESS) && (cnt_q == '0)
                  && we_q && !err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = mem_write;
          f3_d    = funct3;
          addr_d  = address[AW-1:0];
          wdata_d = writedata;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mis_d = err;
          // A clean store keeps the last load result visible.
          if (!we_q) rdata_d = err ? 32'b0 : ld_val;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Forced low during reset even if a request is held.
  assign busywait = reset &
                    (((state_q == S_IDLE) & req) |
                     (state_q == S_ACCESS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Array is never cleared; reset forces IDLE so mem_we drops at once.
  always_ff @(posedge clk) begin
    if (mem_we) mem_array[idx] <= wr_word;
  end

  assign readdata   = rdata_q;
  assign misaligned = mis_q;

endmodule
